// File: rtl/if_stage_pkg.sv
// Shared CPU package: word width, NOP encoding, reset PC, the IF/ID bundle
// type (reused by the ID stage) and the fetch-mode encoding used by the
// next-PC selection in if_stage.
package if_stage_pkg;

  localparam int          WORD_W      = 32;
  localparam logic [31:0] NOP_INSTR_C = 32'h0000_0000;  // sll $0,$0,0
  localparam logic [31:0] RESET_PC_C  = 32'h0000_0000;

  // Contents of the IF/ID pipeline register.
  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] pc4;
    logic              valid;
  } if_id_t;

  // What the fetch stage does this cycle, highest priority first.
  typedef enum logic [1:0] {
    MODE_REDIRECT = 2'd0,
    MODE_STALL    = 2'd1,
    MODE_HALT     = 2'd2,
    MODE_RUN      = 2'd3
  } fetch_mode_t;

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register.
//   clk, rst_n         : clock, asynchronous active-low reset
//   hold               : keep the current contents
//   flush              : load a bubble (NOP, valid 0); wins over hold
//   instr_d/pc4_d/valid_d : next bundle when neither hold nor flush
//   instr_q/pc4_q/valid_q : registered bundle
import if_stage_pkg::*;

module if_id_reg #(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_C
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hold,
  input  logic        flush,
  input  logic [31:0] instr_d,
  input  logic [31:0] pc4_d,
  input  logic        valid_d,
  output logic [31:0] instr_q,
  output logic [31:0] pc4_q,
  output logic        valid_q
);

  if_id_t q_r;
  if_id_t nxt_s;

  // Select the next bundle: bubble, hold, or new fetch.
  always_comb begin
    nxt_s = q_r;
    if (flush) begin
      nxt_s.instr = NOP_INSTR;
      nxt_s.pc4   = q_r.pc4;
      nxt_s.valid = 1'b0;
    end else if (hold) begin
      nxt_s = q_r;
    end else begin
      nxt_s.instr = instr_d;
      nxt_s.pc4   = pc4_d;
      nxt_s.valid = valid_d;
    end
  end

  // Bundle register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r.instr <= NOP_INSTR;
      q_r.pc4   <= 32'h0000_0000;
      q_r.valid <= 1'b0;
    end else begin
      q_r <= nxt_s;
    end
  end

  assign instr_q = q_r.instr;
  assign pc4_q   = q_r.pc4;
  assign valid_q = q_r.valid;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage. Owns the PC, drives the fetch address to a
// combinational instruction memory and captures the returned word into the
// IF/ID register with PC+4 and a valid bit. Handles stall, redirect (flush)
// and halting when fetch would run past the end of memory.
//   clk_i, rst_i (async, active-low)
//   stall_i, redirect_i, redirect_pc_i : control from hazard unit / later stages
//   pc_addr_o -> imem, instr_i <- imem (same cycle)
//   if_id_instr_o, if_id_pc4_o, if_id_valid_o : IF/ID register
//   halted_o, fetch_cnt_o : status
import if_stage_pkg::*;

module if_stage #(
  parameter logic [31:0] RESET_PC   = RESET_PC_C,
  parameter int          IMEM_WORDS = 32,
  parameter logic [31:0] NOP_INSTR  = NOP_INSTR_C
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] pc_addr_o,
  input  logic [31:0] instr_i,
  output logic [31:0] if_id_instr_o,
  output logic [31:0] if_id_pc4_o,
  output logic        if_id_valid_o,
  output logic        halted_o,
  output logic [15:0] fetch_cnt_o
);

  localparam logic [31:0] IMEM_BYTES = 32'(IMEM_WORDS * 4);
  localparam logic [31:0] LAST_ADDR  = IMEM_BYTES - 32'd4;

  logic [31:0] pc_r;
  logic        halted_r;
  logic [15:0] cnt_r;

  logic [31:0] pc4_s;
  logic [31:0] tgt_s;
  logic        tgt_ok_s;
  fetch_mode_t mode_s;
  logic [31:0] pc_nxt_s;
  logic        halted_nxt_s;
  logic        accept_s;
  logic        flush_s;
  logic        hold_s;

  assign pc4_s    = pc_r + 32'd4;
  // Misaligned redirect targets are word-aligned by dropping the low bits.
  assign tgt_s    = redirect_pc_i & ~32'd3;
  assign tgt_ok_s = (tgt_s <= LAST_ADDR);

  // Resolve the cycle's fetch mode by priority.
  always_comb begin
    mode_s = MODE_RUN;
    if (redirect_i) begin
      mode_s = MODE_REDIRECT;
    end else if (stall_i) begin
      mode_s = MODE_STALL;
    end else if (halted_r) begin
      mode_s = MODE_HALT;
    end else begin
      mode_s = MODE_RUN;
    end
  end

  // Next-PC, halt and IF/ID control for the selected mode.
  always_comb begin
    pc_nxt_s     = pc_r;
    halted_nxt_s = halted_r;
    accept_s     = 1'b0;
    flush_s      = 1'b0;
    hold_s       = 1'b0;
    case (mode_s)
      MODE_REDIRECT: begin
        // An out-of-range target still loads the PC but parks fetch.
        pc_nxt_s     = tgt_s;
        halted_nxt_s = ~tgt_ok_s;
        flush_s      = 1'b1;
      end
      MODE_STALL: begin
        hold_s = 1'b1;
      end
      MODE_HALT: begin
        flush_s = 1'b1;
      end
      MODE_RUN: begin
        accept_s = 1'b1;
        // The last word is still accepted; PC then freezes on it.
        if (pc4_s >= IMEM_BYTES) begin
          halted_nxt_s = 1'b1;
          pc_nxt_s     = pc_r;
        end else begin
          halted_nxt_s = 1'b0;
          pc_nxt_s     = pc4_s;
        end
      end
      default: begin
        pc_nxt_s = pc_r;
      end
    endcase
  end

  // PC, halt flag and fetch counter.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pc_r     <= RESET_PC;
      halted_r <= 1'b0;
      cnt_r    <= 16'h0000;
    end else begin
      pc_r     <= pc_nxt_s;
      halted_r <= halted_nxt_s;
      if (accept_s) begin
        cnt_r <= cnt_r + 16'd1;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  if_id_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id_reg (
    .clk     (clk_i),
    .rst_n   (rst_i),
    .hold    (hold_s),
    .flush   (flush_s),
    .instr_d (instr_i),
    .pc4_d   (pc4_s),
    .valid_d (1'b1),
    .instr_q (if_id_instr_o),
    .pc4_q   (if_id_pc4_o),
    .valid_q (if_id_valid_o)
  );

  assign pc_addr_o   = pc_r;
  assign halted_o    = halted_r;
  assign fetch_cnt_o = cnt_r;

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] pc_addr_o;
  logic [31:0] instr_i;
  logic [31:0] if_id_instr_o;
  logic [31:0] if_id_pc4_o;
  logic        if_id_valid_o;
  logic        halted_o;
  logic [15:0] fetch_cnt_o;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  logic [31:0] mem [0:31];

  always #5 clk_i = ~clk_i;

  // combinational instruction memory
  always_comb begin
    if (pc_addr_o < 32'd128) instr_i = mem[pc_addr_o[6:2]];
    else                     instr_i = 32'hDEAD_BEEF;
  end

  if_stage #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_WORDS (32),
    .NOP_INSTR  (32'h0000_0000)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .pc_addr_o     (pc_addr_o),
    .instr_i       (instr_i),
    .if_id_instr_o (if_id_instr_o),
    .if_id_pc4_o   (if_id_pc4_o),
    .if_id_valid_o (if_id_valid_o),
    .halted_o      (halted_o),
    .fetch_cnt_o   (fetch_cnt_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // full snapshot of the stage after an edge
  task automatic snap(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                      input logic [31:0] e_pc4, input logic e_valid, input logic e_halt,
                      input logic [15:0] e_cnt);
    check({tag, ".pc"},    pc_addr_o,              e_pc);
    check({tag, ".instr"}, if_id_instr_o,          e_instr);
    check({tag, ".pc4"},   if_id_pc4_o,            e_pc4);
    check({tag, ".valid"}, {31'd0, if_id_valid_o}, {31'd0, e_valid});
    check({tag, ".halt"},  {31'd0, halted_o},      {31'd0, e_halt});
    check({tag, ".cnt"},   {16'd0, fetch_cnt_o},   {16'd0, e_cnt});
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h0000_1000 + 32'(i);
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;

    rst_i = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
    #3;
    snap("reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 16'd0);
    rst_i = 1'b1;

    // free run
    step(); snap("run1", 32'h4, 32'h11, 32'h4, 1'b1, 1'b0, 16'd1);
    step(); snap("run2", 32'h8, 32'h22, 32'h8, 1'b1, 1'b0, 16'd2);

    // two-cycle stall at pc=8
    stall_i = 1'b1;
    step(); snap("stall1", 32'h8, 32'h22, 32'h8, 1'b1, 1'b0, 16'd2);
    step(); snap("stall2", 32'h8, 32'h22, 32'h8, 1'b1, 1'b0, 16'd2);
    stall_i = 1'b0;
    step(); snap("post_stall", 32'hC, 32'h33, 32'hC, 1'b1, 1'b0, 16'd3);
    step(); snap("run4", 32'h10, 32'h44, 32'h10, 1'b1, 1'b0, 16'd4);

    // redirect + stall together, misaligned target 0x41 -> 0x40
    redirect_i = 1'b1; stall_i = 1'b1; redirect_pc_i = 32'h41;
    step(); snap("redir_stall", 32'h40, 32'h0, 32'h10, 1'b0, 1'b0, 16'd4);
    redirect_i = 1'b0; stall_i = 1'b0;
    step(); snap("redir_tgt", 32'h44, 32'h1010, 32'h44, 1'b1, 1'b0, 16'd5);

    // end of memory
    redirect_i = 1'b1; redirect_pc_i = 32'h78;
    step(); snap("to_end", 32'h78, 32'h0, 32'h44, 1'b0, 1'b0, 16'd5);
    redirect_i = 1'b0;
    step(); snap("word30", 32'h7C, 32'h101E, 32'h7C, 1'b1, 1'b0, 16'd6);
    step(); snap("word31", 32'h7C, 32'h101F, 32'h80, 1'b1, 1'b1, 16'd7);
    step(); snap("halted1", 32'h7C, 32'h0, 32'h80, 1'b0, 1'b1, 16'd7);
    step(); snap("halted2", 32'h7C, 32'h0, 32'h80, 1'b0, 1'b1, 16'd7);
    redirect_i = 1'b1; redirect_pc_i = 32'h0;
    step(); snap("resume", 32'h0, 32'h0, 32'h80, 1'b0, 1'b0, 16'd7);
    redirect_i = 1'b0;
    step(); snap("resume_w0", 32'h4, 32'h11, 32'h4, 1'b1, 1'b0, 16'd8);
    for (int i = 0; i < 7; i++) step();
    snap("at_0x20", 32'h20, 32'h1007, 32'h20, 1'b1, 1'b0, 16'd15);

    // async reset pulse between edges
    rst_i = 1'b0;
    #2;
    snap("async_rst", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 16'd0);
    rst_i = 1'b1;
    step(); snap("restart", 32'h4, 32'h11, 32'h4, 1'b1, 1'b0, 16'd1);

    // out-of-range redirect
    redirect_i = 1'b1; redirect_pc_i = 32'h200;
    step(); snap("oor", 32'h200, 32'h0, 32'h4, 1'b0, 1'b1, 16'd1);
    redirect_i = 1'b0;
    step(); snap("oor_hold", 32'h200, 32'h0, 32'h4, 1'b0, 1'b1, 16'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
